row_stream_mdl: RTL and testbench



---
 rtl/row_stream_mdl.sv | 143 ++++++++++++++
 tb/tb_row_stream_mdl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_stream_mdl.sv
// row_stream_mdl : matrix-to-row serializer (transmit end of the row-buffer link).
//
// Captures a full matrix (COLUMN_SIZE rows x ROW_SIZE elements x DATA_SIZE bits)
// on a load strobe. It then emits the matrix one row per accepted valid/ready
// beat, most-significant row slice first. A single end-of-matrix pulse follows
// the last row.
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high
//   enable      in   global advance qualifier; low freezes every register
//   dsetFlag    in   load strobe, datsIn valid in the same cycle
//   datsIn      in   MAT_W  matrix, row k = datsIn[MAT_W-1-k*ROW_W -: ROW_W]
//   dready      in   downstream accepts the current row
//   dats        out  ROW_W  current row (holds the last row after completion)
//   dvalidFlag  out  dats is valid
//   dendFlag    out  one-cycle end-of-matrix pulse (dats not valid then)
//   busy        out  high while sending or signalling end of matrix
//   dropFlag    out  one-cycle pulse when a load strobe is ignored
module row_stream_mdl #(
  parameter int DATA_SIZE   = 16,
  parameter int COLUMN_SIZE = 64,
  parameter int ROW_SIZE    = 64
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    enable,
  input  logic                                    dsetFlag,
  input  logic [DATA_SIZE*ROW_SIZE*COLUMN_SIZE-1:0] datsIn,
  input  logic                                    dready,
  output logic [DATA_SIZE*ROW_SIZE-1:0]           dats,
  output logic                                    dvalidFlag,
  output logic                                    dendFlag,
  output logic                                    busy,
  output logic                                    dropFlag
);

  localparam int ROW_W = DATA_SIZE * ROW_SIZE;
  localparam int MAT_W = ROW_W * COLUMN_SIZE;
  localparam int CNT_W = $clog2(COLUMN_SIZE) + 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(COLUMN_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_END  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [MAT_W-1:0]     shadow, shadow_nxt;
  logic [ROW_W-1:0]     dats_nxt;
  logic                 vld_nxt;
  logic                 end_nxt;
  logic                 busy_nxt;
  logic                 drop_nxt;
  logic                 accept;

  // Row k sits at the top of the matrix word after shifting k rows out.
  function automatic logic [ROW_W-1:0] row_of(input logic [MAT_W-1:0] mat,
                                              input logic [CNT_W-1:0] idx);
    logic [MAT_W-1:0] shifted;
    shifted = mat << (int'(idx) * ROW_W);
    return shifted[MAT_W-1 -: ROW_W];
  endfunction

  assign accept = enable & dvalidFlag & dready;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    shadow_nxt = shadow;
    dats_nxt   = dats;
    vld_nxt    = dvalidFlag;
    end_nxt    = dendFlag;
    busy_nxt   = busy;
    drop_nxt   = dropFlag;

    // With enable low everything, including pulses already high, holds.
    if (enable) begin
      drop_nxt = 1'b0;
      unique case (state)
        S_IDLE: begin
          if (dsetFlag) begin
            shadow_nxt = datsIn;
            cnt_nxt    = '0;
            dats_nxt   = row_of(datsIn, '0);
            vld_nxt    = 1'b1;
            state_nxt  = S_SEND;
          end
        end
        S_SEND: begin
          drop_nxt = dsetFlag;
          if (accept) begin
            if (cnt < LAST_ROW) begin
              cnt_nxt  = cnt + CNT_W'(1);
              dats_nxt = row_of(shadow, cnt + CNT_W'(1));
            end else begin
              // dats keeps the last row after the matrix completes.
              vld_nxt   = 1'b0;
              end_nxt   = 1'b1;
              state_nxt = S_END;
            end
          end
        end
        S_END: begin
          drop_nxt  = dsetFlag;
          end_nxt   = 1'b0;
          state_nxt = S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
          vld_nxt   = 1'b0;
          end_nxt   = 1'b0;
        end
      endcase
      busy_nxt = (state_nxt != S_IDLE);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      shadow     <= '0;
      dats       <= '0;
      dvalidFlag <= 1'b0;
      dendFlag   <= 1'b0;
      busy       <= 1'b0;
      dropFlag   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      shadow     <= shadow_nxt;
      dats       <= dats_nxt;
      dvalidFlag <= vld_nxt;
      dendFlag   <= end_nxt;
      busy       <= busy_nxt;
      dropFlag   <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_row_stream_mdl.sv
// tb_row_stream_mdl : directed bench for row_stream_mdl with a row scoreboard.
// Expected rows and end-of-matrix markers are queued when a load is driven.
// They are popped when the DUT hands over a beat.
module tb_row_stream_mdl;

  localparam int DATA_SIZE   = 8;
  localparam int ROW_SIZE    = 2;
  localparam int COLUMN_SIZE = 4;
  localparam int ROW_W       = DATA_SIZE * ROW_SIZE;
  localparam int MAT_W       = ROW_W * COLUMN_SIZE;

  localparam logic [MAT_W-1:0] M1 = 64'h0011_2233_4455_6677;
  localparam logic [MAT_W-1:0] M2 = 64'h0102_0304_0506_0708;
  localparam logic [MAT_W-1:0] M3 = 64'hA1A2_B1B2_C1C2_D1D2;

  logic             clock = 1'b0;
  logic             reset;
  logic             enable;
  logic             dsetFlag;
  logic [MAT_W-1:0] datsIn;
  logic             dready;
  logic [ROW_W-1:0] dats;
  logic             dvalidFlag;
  logic             dendFlag;
  logic             busy;
  logic             dropFlag;

  int errors = 0;
  int checks = 0;

  // {is_end_marker, row}
  logic [ROW_W:0] sb[$];

  row_stream_mdl #(
    .DATA_SIZE  (DATA_SIZE),
    .COLUMN_SIZE(COLUMN_SIZE),
    .ROW_SIZE   (ROW_SIZE)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .dsetFlag  (dsetFlag),
    .datsIn    (datsIn),
    .dready    (dready),
    .dats      (dats),
    .dvalidFlag(dvalidFlag),
    .dendFlag  (dendFlag),
    .busy      (busy),
    .dropFlag  (dropFlag)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input logic [ROW_W-1:0] obs,
                         input logic [ROW_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_mat(input logic [MAT_W-1:0] m);
    for (int k = 0; k < COLUMN_SIZE; k++)
      sb.push_back({1'b0, m[MAT_W-1-k*ROW_W -: ROW_W]});
    sb.push_back({1'b1, {ROW_W{1'b0}}});
  endtask

  task automatic load(input logic [MAT_W-1:0] m);
    dsetFlag = 1'b1;
    datsIn   = m;
    tick();
    dsetFlag = 1'b0;
  endtask

  task automatic wait_end();
    int n = 0;
    while (!dendFlag && n < 20) begin
      tick();
      n++;
    end
    check1("end_seen", dendFlag, 1'b1);
  endtask

  // Scoreboard monitor: at the falling edge the inputs are those the next
  // rising edge will sample, so a beat seen here is one the DUT hands over.
  always @(negedge clock) begin
    logic [ROW_W:0] exp_item;
    if (!reset && enable) begin
      if (dvalidFlag && dready) begin
        if (sb.size() > 0) exp_item = sb.pop_front();
        else               exp_item = {1'b1, {ROW_W{1'b1}}};
        checks++;
        assert ({1'b0, dats} === exp_item) else begin
          errors++;
          $error("FAIL row_out observed=%h expected=%h", {1'b0, dats}, exp_item);
        end
      end
      if (dendFlag) begin
        if (sb.size() > 0) exp_item = sb.pop_front();
        else               exp_item = {1'b0, {ROW_W{1'b1}}};
        checks++;
        assert ({dendFlag, {ROW_W{1'b0}}} === exp_item) else begin
          errors++;
          $error("FAIL end_marker observed=%h expected=%h",
                 {dendFlag, {ROW_W{1'b0}}}, exp_item);
        end
        check1("end_novalid", dvalidFlag, 1'b0);
      end
    end
  end

  initial begin
    reset    = 1'b1;
    enable   = 1'b1;
    dsetFlag = 1'b0;
    dready   = 1'b0;
    datsIn   = '0;
    tick();
    tick();
    check16("rst_dats", dats, 16'h0000);
    check1("rst_valid", dvalidFlag, 1'b0);
    check1("rst_end", dendFlag, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_drop", dropFlag, 1'b0);
    reset = 1'b0;
    tick();

    // Basic stream
    dready = 1'b1;
    expect_mat(M1);
    load(M1);
    check1("basic_valid0", dvalidFlag, 1'b1);
    check16("basic_row0", dats, 16'h0011);
    check1("basic_busy", busy, 1'b1);
    tick();
    check16("basic_row1", dats, 16'h2233);
    tick();
    check16("basic_row2", dats, 16'h4455);
    tick();
    check16("basic_row3", dats, 16'h6677);
    tick();
    check1("basic_end", dendFlag, 1'b1);
    check1("basic_end_valid", dvalidFlag, 1'b0);
    check1("basic_end_busy", busy, 1'b1);
    tick();
    check1("basic_idle_end", dendFlag, 1'b0);
    check1("basic_idle_busy", busy, 1'b0);
    check16("basic_hold_last", dats, 16'h6677);

    // Backpressure on row 1
    expect_mat(M1);
    load(M1);
    tick();
    check16("bp_row1", dats, 16'h2233);
    dready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check16("bp_hold_row", dats, 16'h2233);
      check1("bp_hold_valid", dvalidFlag, 1'b1);
    end
    dready = 1'b1;
    tick();
    check16("bp_row2", dats, 16'h4455);
    wait_end();
    tick();

    // Overrun during row 2, then a load in the following IDLE cycle
    expect_mat(M1);
    load(M1);
    tick();
    tick();
    check16("ovr_row2", dats, 16'h4455);
    dsetFlag = 1'b1;
    datsIn   = '1;
    tick();
    dsetFlag = 1'b0;
    check1("ovr_drop", dropFlag, 1'b1);
    check16("ovr_row3", dats, 16'h6677);
    tick();
    check1("ovr_drop_once", dropFlag, 1'b0);
    check1("ovr_end", dendFlag, 1'b1);
    tick();
    check1("ovr_idle_busy", busy, 1'b0);
    expect_mat(M2);
    load(M2);
    check1("ovr_reload_valid", dvalidFlag, 1'b1);
    check16("ovr_reload_row0", dats, 16'h0102);
    check1("ovr_reload_nodrop", dropFlag, 1'b0);
    wait_end();
    tick();

    // Enable freeze mid-stream and while the end pulse is high
    expect_mat(M3);
    load(M3);
    tick();
    check16("frz_row1", dats, 16'hB1B2);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check16("frz_row_hold", dats, 16'hB1B2);
      check1("frz_valid_hold", dvalidFlag, 1'b1);
      check1("frz_busy_hold", busy, 1'b1);
    end
    enable = 1'b1;
    tick();
    check16("frz_resume_row2", dats, 16'hC1C2);
    tick();
    check16("frz_row3", dats, 16'hD1D2);
    tick();
    check1("frz_end", dendFlag, 1'b1);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check1("frz_end_hold", dendFlag, 1'b1);
      check1("frz_end_valid", dvalidFlag, 1'b0);
      check1("frz_end_busy", busy, 1'b1);
    end
    enable = 1'b1;
    tick();
    check1("frz_end_release", dendFlag, 1'b0);
    check1("frz_idle_busy", busy, 1'b0);

    // Reset during row 1
    expect_mat(M1);
    load(M1);
    tick();
    check16("rmid_row1", dats, 16'h2233);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    check16("rmid_dats", dats, 16'h0000);
    check1("rmid_valid", dvalidFlag, 1'b0);
    check1("rmid_end", dendFlag, 1'b0);
    check1("rmid_busy", busy, 1'b0);
    check1("rmid_drop", dropFlag, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check1("rmid_no_end", dendFlag, 1'b0);
    end
    expect_mat(M2);
    load(M2);
    check16("rmid_restart_row0", dats, 16'h0102);
    check1("rmid_restart_valid", dvalidFlag, 1'b1);
    wait_end();
    tick();

    // Back-to-back loads at the minimum spacing of COLUMN_SIZE+2 edges
    expect_mat(M1);
    expect_mat(M3);
    load(M1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check1("b2b_nodrop", dropFlag, 1'b0);
    end
    check1("b2b_idle", busy, 1'b0);
    load(M3);
    check1("b2b_second_valid", dvalidFlag, 1'b1);
    check16("b2b_second_row0", dats, 16'hA1A2);
    check1("b2b_second_nodrop", dropFlag, 1'b0);
    wait_end();
    tick();
    check1("b2b_final_busy", busy, 1'b0);
    check1("b2b_final_nodrop", dropFlag, 1'b0);
    tick();

    check_int("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
